// File: rtl/rob_seq_ctrl.sv
// Sequencing controller for the 2-wide ROB: dispatch index allocation with full back-pressure,
// two-oldest commit selection with single-store serialisation, and flush/recovery sequencing.
module rob_seq_ctrl #(
    parameter int ROB_WIDTH      = 6,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [1:0]               disp_req_i,
    output logic                     disp_ready_o,
    output logic [1:0]               disp_fire_o,
    output logic [2*ROB_WIDTH-1:0]   disp_idx_o,
    input  logic [1:0]               cmt_valid_i,
    input  logic [1:0]               cmt_w_mem_i,
    input  logic [1:0]               cmt_exc_i,
    input  logic                     sb_ready_i,
    output logic [1:0]               commit_req_o,
    output logic                     flush_req_o,
    output logic [ROB_WIDTH:0]       rob_cnt_o
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_RECOVER  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROB_WIDTH-1:0]   head_q, head_d;
    logic [ROB_WIDTH:0]     cnt_q, cnt_d;
    logic [RC_W-1:0]        rc_q, rc_d;

    logic                   c0, c1;
    logic                   commit_ok;
    logic [ROB_WIDTH:0]     fire_cnt, cmt_cnt;

    // Handshake: a dispatch slot transfers on a cycle where disp_req_i[n] and disp_ready_o are
    // both high (disp_fire_o[n]); ready never depends on req, and is granted to both slots or neither.
    assign disp_ready_o = (state_q == S_RUN) && (cnt_q <= (ROB_WIDTH+1)'(DEPTH - 2)) && !flush_i;
    assign disp_fire_o  = disp_req_i & {2{disp_ready_o}};
    assign disp_idx_o   = {head_q + ROB_WIDTH'(1), head_q};

    // Slot1 may follow slot0 only when neither excepts and at most one of them is a store.
    assign c0 = cmt_valid_i[0] & (~cmt_w_mem_i[0] | sb_ready_i);
    assign c1 = c0 & ~cmt_exc_i[0] & cmt_valid_i[1] & ~cmt_exc_i[1]
              & ~(cmt_w_mem_i[0] & cmt_w_mem_i[1]) & (~cmt_w_mem_i[1] | sb_ready_i);

    assign commit_ok    = (state_q == S_RUN) && !flush_i;
    assign commit_req_o = {c1, c0} & {2{commit_ok}};

    assign fire_cnt = (ROB_WIDTH+1)'(disp_fire_o[0]) + (ROB_WIDTH+1)'(disp_fire_o[1]);
    assign cmt_cnt  = (ROB_WIDTH+1)'(commit_req_o[0]) + (ROB_WIDTH+1)'(commit_req_o[1]);

    assign flush_req_o = (state_q == S_REDIRECT);
    assign rob_cnt_o   = cnt_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q + fire_cnt[ROB_WIDTH-1:0];
        cnt_d   = cnt_q + fire_cnt - cmt_cnt;
        rc_d    = rc_q;
        if (flush_i) begin
            state_d = S_RECOVER;
            head_d  = '0;
            cnt_d   = '0;
            rc_d    = RC_W'(RECOVER_CYCLES);
        end else begin
            case (state_q)
                S_RUN: begin
                    if (commit_req_o[0] && cmt_exc_i[0]) state_d = S_REDIRECT;
                end
                S_REDIRECT: begin
                    state_d = S_REDIRECT;
                end
                S_RECOVER: begin
                    if (rc_q <= RC_W'(1)) state_d = S_RUN;
                    if (rc_q != '0) rc_d = rc_q - RC_W'(1);
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            head_q  <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
        end
    end

endmodule

// File: tb/tb_rob_seq_ctrl.sv
// Directed and constrained-random bench for rob_seq_ctrl; dispatch indices are scoreboarded
// through an expected queue and all other outputs are checked against a cycle model.
module tb_rob_seq_ctrl;

    localparam int M_RUN      = 0;
    localparam int M_REDIRECT = 1;
    localparam int M_RECOVER  = 2;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  disp_req_i;
    logic        disp_ready_o;
    logic [1:0]  disp_fire_o;
    logic [11:0] disp_idx_o;
    logic [1:0]  cmt_valid_i;
    logic [1:0]  cmt_w_mem_i;
    logic [1:0]  cmt_exc_i;
    logic        sb_ready_i;
    logic [1:0]  commit_req_o;
    logic        flush_req_o;
    logic [6:0]  rob_cnt_o;

    int          n_checks;
    int          n_fails;
    logic [13:0] exp_q[$];

    int          m_state;
    int          m_cnt;
    int          m_rc;
    logic [5:0]  m_head;

    rob_seq_ctrl #(.ROB_WIDTH(6), .RECOVER_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .disp_req_i   (disp_req_i),
        .disp_ready_o (disp_ready_o),
        .disp_fire_o  (disp_fire_o),
        .disp_idx_o   (disp_idx_o),
        .cmt_valid_i  (cmt_valid_i),
        .cmt_w_mem_i  (cmt_w_mem_i),
        .cmt_exc_i    (cmt_exc_i),
        .sb_ready_i   (sb_ready_i),
        .commit_req_o (commit_req_o),
        .flush_req_o  (flush_req_o),
        .rob_cnt_o    (rob_cnt_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every dispatch fire pops one expected {fire, idx1, idx0}
    always @(negedge clk) begin
        if (rst_n && disp_fire_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("disp_unexpected_fire", {18'd0, disp_fire_o, disp_idx_o}, 32'd0);
            end else begin
                check("disp_idx", {18'd0, disp_fire_o, disp_idx_o}, {18'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_idle();
        flush_i     = 1'b0;
        disp_req_i  = 2'b00;
        cmt_valid_i = 2'b00;
        cmt_w_mem_i = 2'b00;
        cmt_exc_i   = 2'b00;
        sb_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_state = M_RUN;
        m_cnt   = 0;
        m_rc    = 0;
        m_head  = 6'd0;
        exp_q.delete();
        @(negedge clk);
        check("rst_ready", disp_ready_o, 1);
        check("rst_commit", commit_req_o, 0);
        check("rst_flush_req", flush_req_o, 0);
        check("rst_cnt", rob_cnt_o, 0);
    endtask

    // driver: one cycle of stimulus, model prediction, and update of the model at the edge
    task automatic step(input logic [1:0] req, input logic [1:0] cv, input logic [1:0] wm,
                        input logic [1:0] ex, input logic sbr, input logic fl);
        logic       e_ready;
        logic [1:0] e_fire;
        logic [1:0] e_cmt;
        logic       p0, p1;
        logic [5:0] h1;
        @(posedge clk);
        #1;
        disp_req_i  = req;
        cmt_valid_i = cv;
        cmt_w_mem_i = wm;
        cmt_exc_i   = ex;
        sb_ready_i  = sbr;
        flush_i     = fl;
        e_ready = (m_state == M_RUN) && (m_cnt <= 62) && !fl;
        e_fire  = req & {2{e_ready}};
        p0 = cv[0] & (!wm[0] | sbr);
        p1 = p0 & !ex[0] & cv[1] & !ex[1] & !(wm[0] & wm[1]) & (!wm[1] | sbr);
        e_cmt = (m_state == M_RUN && !fl) ? {p1, p0} : 2'b00;
        h1 = m_head + 6'd1;
        if (e_fire != 2'b00) exp_q.push_back({e_fire, h1, m_head});
        @(negedge clk);
        check("disp_ready", disp_ready_o, e_ready);
        check("commit_req", commit_req_o, e_cmt);
        check("flush_req", flush_req_o, m_state == M_REDIRECT);
        check("rob_cnt", rob_cnt_o, m_cnt);
        if (fl) begin
            m_state = M_RECOVER;
            m_head  = 6'd0;
            m_cnt   = 0;
            m_rc    = 2;
        end else begin
            m_head = m_head + 6'(e_fire[0]) + 6'(e_fire[1]);
            m_cnt  = m_cnt + int'(e_fire[0]) + int'(e_fire[1]) - int'(e_cmt[0]) - int'(e_cmt[1]);
            if (m_state == M_RUN && e_cmt[0] && ex[0]) begin
                m_state = M_REDIRECT;
            end else if (m_state == M_RECOVER) begin
                if (m_rc <= 1) m_state = M_RUN;
                if (m_rc > 0) m_rc = m_rc - 1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive_idle();
        do_reset();

        // T1 fill: pairs (0,1)..(62,63), then back-pressure at 64
        for (int i = 0; i < 34; i++) step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t1_cnt_cap", rob_cnt_o, 64);
        check("t1_ready_low", disp_ready_o, 0);

        // drain, then build cnt=10 with head=62
        for (int i = 0; i < 32; i++) step(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 26; i++) step(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);

        // T2 wrap
        step(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        check("t2_idx", disp_idx_o, {6'd63, 6'd62});
        step(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t2_cnt", rob_cnt_o, 10);
        check("t2_head_wrap", disp_idx_o, {6'd1, 6'd0});

        // T3 stores
        step(2'b00, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0);
        check("t3_one_store", commit_req_o, 2'b01);
        step(2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        check("t3_sb_busy", commit_req_o, 2'b00);

        // T4 exception in slot0, redirect held, flush, two recovery cycles
        step(2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0);
        check("t4_exc_alone", commit_req_o, 2'b01);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        check("t4_flush_req", flush_req_o, 1);
        step(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        check("t4_redirect_no_commit", commit_req_o, 2'b00);
        check("t4_redirect_no_fire", disp_fire_o, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        check("t4_flush_req_held", flush_req_o, 1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t4_cnt_cleared", rob_cnt_o, 0);
        check("t4_stall1", disp_ready_o, 0);
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t4_stall2", disp_ready_o, 0);
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t4_run_again", disp_ready_o, 1);
        check("t4_idx_from_zero", disp_idx_o, {6'd1, 6'd0});

        // T5 exception first seen in slot1
        step(2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0);
        check("t5_slot1_exc_held", commit_req_o, 2'b01);
        step(2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
        check("t5_exc_commits", commit_req_o, 2'b01);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t5_redirect", flush_req_o, 1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // T6 flush wins over same-cycle dispatch and commit
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1);
        check("t6_no_fire", disp_fire_o, 2'b00);
        check("t6_no_commit", commit_req_o, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t6_cnt_zero", rob_cnt_o, 0);
        check("t6_recover", disp_ready_o, 0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("t6_head_zero", disp_idx_o, {6'd1, 6'd0});

        // reset mid-operation
        for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        do_reset();

        // constrained random: commit valids never exceed the modelled occupancy
        for (int i = 0; i < 300; i++) begin
            logic [1:0] r_req, r_cv, r_wm, r_ex;
            logic       r_sb, r_fl;
            r_req = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01);
            r_cv  = 2'b00;
            if (m_cnt >= 1 && $urandom_range(0, 3) != 0) r_cv[0] = 1'b1;
            if (r_cv[0] && m_cnt >= 2 && $urandom_range(0, 1) == 1) r_cv[1] = 1'b1;
            r_wm  = 2'($urandom_range(0, 3));
            r_ex  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_sb  = 1'($urandom_range(0, 1));
            r_fl  = (m_state == M_REDIRECT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            step(r_req, r_cv, r_wm, r_ex, r_sb, r_fl);
        end

        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
